// File: rtl/nios_led1_pio_pkg.sv
// Shared constants for the Nios II system PIO blocks: Avalon word map and edge-capture modes.
package nios_led1_pio_pkg;

    localparam logic [1:0] ADDR_DATA     = 2'd0;
    localparam logic [1:0] ADDR_RSVD     = 2'd1;
    localparam logic [1:0] ADDR_IRQ_MASK = 2'd2;
    localparam logic [1:0] ADDR_EDGE_CAP = 2'd3;

    localparam int unsigned EDGE_RISE = 0;
    localparam int unsigned EDGE_FALL = 1;
    localparam int unsigned EDGE_ANY  = 2;

endpackage

// File: rtl/nios_led1_debounce.sv
// Single-bit two-flop synchronizer followed by a consecutive-cycle debouncer.
module nios_led1_debounce #(
    parameter int unsigned DEBOUNCE_CYCLES = 4,
    parameter logic        RESET_BIT       = 1'b0
) (
    input  logic clk,
    input  logic reset_n,
    input  logic i_async,
    output logic o_debounced
);

    localparam int unsigned        CNT_W    = $clog2(DEBOUNCE_CYCLES) + 1;
    localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             r_sync1;
    logic             r_sync2;
    logic             r_deb;
    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_sync1 <= RESET_BIT;
            r_sync2 <= RESET_BIT;
            r_deb   <= RESET_BIT;
            r_cnt   <= '0;
        end else begin
            r_sync1 <= i_async;
            r_sync2 <= r_sync1;
            // Any return to the accepted level restarts qualification from zero.
            if (r_sync2 == r_deb) begin
                r_cnt <= '0;
            end else if (r_cnt == CNT_LAST) begin
                r_deb <= r_sync2;
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
        end
    end

    assign o_debounced = r_deb;

endmodule

// File: rtl/nios_led1_button.sv
// Avalon-MM input PIO: debounced board inputs, sticky edge capture and masked level interrupt.
module nios_led1_button
    import nios_led1_pio_pkg::*;
#(
    parameter int unsigned      WIDTH           = 2,
    parameter int unsigned      DEBOUNCE_CYCLES = 4,
    parameter int unsigned      EDGE_TYPE       = 0,
    parameter logic [WIDTH-1:0] INPUT_RESET     = '0
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    input  logic [WIDTH-1:0] in_port,
    output logic             irq
);

    logic [WIDTH-1:0] w_deb;
    logic [WIDTH-1:0] w_edge;
    logic [WIDTH-1:0] w_cap_next;
    logic             w_wr;
    logic             w_unused_wdata;

    logic [WIDTH-1:0] r_prev;
    logic [WIDTH-1:0] r_mask;
    logic [WIDTH-1:0] r_cap;

    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
        nios_led1_debounce #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .RESET_BIT       (INPUT_RESET[gi])
        ) u_debounce (
            .clk         (clk),
            .reset_n     (reset_n),
            .i_async     (in_port[gi]),
            .o_debounced (w_deb[gi])
        );
    end

    assign w_wr           = chipselect & ~write_n;
    assign w_unused_wdata = ^writedata;

    always_comb begin
        w_edge = '0;
        case (EDGE_TYPE)
            EDGE_FALL: w_edge = ~w_deb & r_prev;
            EDGE_ANY:  w_edge = w_deb ^ r_prev;
            default:   w_edge = w_deb & ~r_prev;
        endcase
    end

    // Edge set is applied after the W1C clear so a coincident edge is never lost.
    always_comb begin
        w_cap_next = r_cap;
        if (w_wr && (address == ADDR_EDGE_CAP)) begin
            w_cap_next = r_cap & ~writedata[WIDTH-1:0];
        end
        w_cap_next = w_cap_next | w_edge;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_prev <= INPUT_RESET;
            r_mask <= '0;
            r_cap  <= '0;
        end else begin
            r_prev <= w_deb;
            r_cap  <= w_cap_next;
            if (w_wr && (address == ADDR_IRQ_MASK)) begin
                r_mask <= writedata[WIDTH-1:0];
            end
        end
    end

    always_comb begin
        readdata = '0;
        unique case (address)
            ADDR_DATA:     readdata[WIDTH-1:0] = w_deb;
            ADDR_RSVD:     readdata = '0;
            ADDR_IRQ_MASK: readdata[WIDTH-1:0] = r_mask;
            ADDR_EDGE_CAP: readdata[WIDTH-1:0] = r_cap;
        endcase
    end

    assign irq = |(r_cap & r_mask);

endmodule

// File: tb/tb_nios_led1_button.sv
// Self-checking bench for nios_led1_button: directed scenarios plus a randomized run
// against a cycle-level behavioural model of the input PIO.
module tb_nios_led1_button;

    localparam int unsigned WIDTH = 2;
    localparam int unsigned DEB   = 4;

    logic             clk = 1'b0;
    logic             reset_n;
    logic [1:0]       address;
    logic             chipselect;
    logic             write_n;
    logic [31:0]      writedata;
    logic [31:0]      readdata;
    logic [WIDTH-1:0] in_port;
    logic             irq;

    int total = 0;
    int bad   = 0;

    // Behavioural model: two sample delays, then a level is accepted once it has been seen
    // differing from the accepted value for DEB consecutive samples.
    logic [WIDTH-1:0] m_s1, m_s2, m_deb, m_prev, m_cap, m_mask;
    int               m_run [WIDTH];

    nios_led1_button #(
        .WIDTH           (WIDTH),
        .DEBOUNCE_CYCLES (DEB),
        .EDGE_TYPE       (0),
        .INPUT_RESET     (2'b00)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .address    (address),
        .chipselect (chipselect),
        .write_n    (write_n),
        .writedata  (writedata),
        .readdata   (readdata),
        .in_port    (in_port),
        .irq        (irq)
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        m_s1 = '0; m_s2 = '0; m_deb = '0; m_prev = '0; m_cap = '0; m_mask = '0;
        for (int b = 0; b < WIDTH; b++) m_run[b] = 0;
    endtask

    function automatic logic [31:0] exp_read(input logic [1:0] a);
        logic [31:0] r;
        r = '0;
        case (a)
            2'd0:    r[WIDTH-1:0] = m_deb;
            2'd2:    r[WIDTH-1:0] = m_mask;
            2'd3:    r[WIDTH-1:0] = m_cap;
            default: r = '0;
        endcase
        return r;
    endfunction

    // One clock edge; the model advances using the inputs that were stable at the edge.
    task automatic tick();
        logic [WIDTH-1:0] in_s, nd;
        logic             wr;
        logic [1:0]       a;
        logic [31:0]      wd;
        in_s = in_port;
        wr   = chipselect && !write_n;
        a    = address;
        wd   = writedata;
        @(posedge clk);
        #1;
        if (!reset_n) begin
            model_reset();
        end else begin
            if (wr && a == 2'd3) m_cap = m_cap & ~wd[WIDTH-1:0];
            m_cap = m_cap | (m_deb & ~m_prev);
            if (wr && a == 2'd2) m_mask = wd[WIDTH-1:0];
            m_prev = m_deb;
            nd = m_deb;
            for (int b = 0; b < WIDTH; b++) begin
                if (m_s2[b] != m_deb[b]) begin
                    m_run[b]++;
                    if (m_run[b] >= DEB) begin
                        nd[b]    = m_s2[b];
                        m_run[b] = 0;
                    end
                end else begin
                    m_run[b] = 0;
                end
            end
            m_deb = nd;
            m_s2  = m_s1;
            m_s1  = in_s;
        end
    endtask

    task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
        address = a; writedata = d; chipselect = 1'b1; write_n = 1'b0;
        tick();
        chipselect = 1'b0; write_n = 1'b1;
    endtask

    task automatic test_reset();
        logic [1:0] addrs [3];
        addrs[0] = 2'd0; addrs[1] = 2'd2; addrs[2] = 2'd3;
        reset_n = 1'b0; in_port = '0; address = '0; chipselect = 1'b0; write_n = 1'b1;
        writedata = '0;
        model_reset();
        repeat (3) tick();
        reset_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            address = addrs[i];
            #1;
            total++;
            if (readdata !== 32'h0) begin
                bad++;
                $display("FAIL reset_read addr=%0d got=%h want=%h", addrs[i], readdata, 32'h0);
            end
        end
        total++;
        if (irq !== 1'b0) begin
            bad++;
            $display("FAIL reset_irq got=%b want=0", irq);
        end
    endtask

    task automatic test_rise_latency();
        in_port = 2'b01;
        address = 2'd0;
        repeat (5) tick();
        total++;
        if (readdata !== 32'h0) begin
            bad++;
            $display("FAIL rise_at5 got=%h want=%h", readdata, 32'h0);
        end
        tick();
        total++;
        if (readdata !== 32'h1) begin
            bad++;
            $display("FAIL rise_at6 got=%h want=%h", readdata, 32'h1);
        end
        address = 2'd3;
        #1;
        total++;
        if (readdata !== 32'h0) begin
            bad++;
            $display("FAIL cap_before_edge got=%h want=%h", readdata, 32'h0);
        end
        tick();
        total++;
        if (readdata !== 32'h1) begin
            bad++;
            $display("FAIL cap_at7 got=%h want=%h", readdata, 32'h1);
        end
        total++;
        if (irq !== 1'b0) begin
            bad++;
            $display("FAIL irq_masked got=%b want=0", irq);
        end
    endtask

    task automatic test_glitch();
        in_port = 2'b11;
        repeat (3) tick();
        in_port = 2'b01;
        for (int i = 0; i < 8; i++) begin
            tick();
            address = 2'd0;
            #1;
            total++;
            if (readdata !== 32'h1) begin
                bad++;
                $display("FAIL glitch_data cyc=%0d got=%h want=%h", i, readdata, 32'h1);
            end
            address = 2'd3;
            #1;
            total++;
            if (readdata !== 32'h1) begin
                bad++;
                $display("FAIL glitch_cap cyc=%0d got=%h want=%h", i, readdata, 32'h1);
            end
        end
        in_port = 2'b11;
        address = 2'd0;
        repeat (5) tick();
        total++;
        if (readdata !== 32'h1) begin
            bad++;
            $display("FAIL hold_at5 got=%h want=%h", readdata, 32'h1);
        end
        tick();
        total++;
        if (readdata !== 32'h3) begin
            bad++;
            $display("FAIL hold_at6 got=%h want=%h", readdata, 32'h3);
        end
        tick();
        address = 2'd3;
        #1;
        total++;
        if (readdata !== 32'h3) begin
            bad++;
            $display("FAIL hold_cap got=%h want=%h", readdata, 32'h3);
        end
    endtask

    task automatic test_irq_mask();
        bus_write(2'd3, 32'h2);
        address = 2'd3;
        #1;
        total++;
        if (readdata !== 32'h1 || irq !== 1'b0) begin
            bad++;
            $display("FAIL w1c_bit1 got=%h/%b want=%h/0", readdata, irq, 32'h1);
        end
        bus_write(2'd2, 32'h3);
        total++;
        if (irq !== 1'b1) begin
            bad++;
            $display("FAIL irq_on_mask got=%b want=1", irq);
        end
        address = 2'd2;
        #1;
        total++;
        if (readdata !== 32'h3) begin
            bad++;
            $display("FAIL mask_read got=%h want=%h", readdata, 32'h3);
        end
        bus_write(2'd3, 32'h1);
        address = 2'd3;
        #1;
        total++;
        if (readdata !== 32'h0 || irq !== 1'b0) begin
            bad++;
            $display("FAIL w1c_clear got=%h/%b want=%h/0", readdata, irq, 32'h0);
        end
    endtask

    task automatic test_w1c_collision();
        in_port = 2'b10;
        repeat (8) tick();
        address = 2'd3;
        #1;
        total++;
        if (readdata !== 32'h0) begin
            bad++;
            $display("FAIL fall_not_captured got=%h want=%h", readdata, 32'h0);
        end
        in_port = 2'b11;
        repeat (6) tick();
        bus_write(2'd3, 32'h1);
        address = 2'd3;
        #1;
        total++;
        if (readdata !== 32'h1 || irq !== 1'b1) begin
            bad++;
            $display("FAIL set_wins got=%h/%b want=%h/1", readdata, irq, 32'h1);
        end
        bus_write(2'd3, 32'h3);
    endtask

    task automatic test_reset_mid_debounce();
        reset_n = 1'b0; in_port = 2'b00;
        model_reset();
        repeat (2) tick();
        reset_n = 1'b1;
        repeat (2) tick();
        in_port = 2'b01;
        repeat (4) tick();
        reset_n = 1'b0;
        model_reset();
        address = 2'd0;
        #1;
        total++;
        if (readdata !== 32'h0) begin
            bad++;
            $display("FAIL mid_reset_data got=%h want=%h", readdata, 32'h0);
        end
        repeat (2) tick();
        reset_n = 1'b1;
        repeat (5) tick();
        total++;
        if (readdata !== 32'h0) begin
            bad++;
            $display("FAIL requal_at5 got=%h want=%h", readdata, 32'h0);
        end
        tick();
        total++;
        if (readdata !== 32'h1) begin
            bad++;
            $display("FAIL requal_at6 got=%h want=%h", readdata, 32'h1);
        end
        bus_write(2'd1, 32'hFFFF_FFFF);
        address = 2'd1;
        #1;
        total++;
        if (readdata !== 32'h0) begin
            bad++;
            $display("FAIL rsvd_read got=%h want=%h", readdata, 32'h0);
        end
        bus_write(2'd0, 32'h0);
        address = 2'd0;
        #1;
        total++;
        if (readdata !== 32'h1) begin
            bad++;
            $display("FAIL data_ro got=%h want=%h", readdata, 32'h1);
        end
        address = 2'd2; writedata = 32'h3; chipselect = 1'b0; write_n = 1'b0;
        tick();
        write_n = 1'b1;
        #1;
        total++;
        if (readdata !== 32'h0 || irq !== 1'b0) begin
            bad++;
            $display("FAIL cs_low_write got=%h/%b want=%h/0", readdata, irq, 32'h0);
        end
    endtask

    task automatic test_random();
        int hold;
        int op;
        hold = 0;
        for (int i = 0; i < 800; i++) begin
            if (hold == 0) begin
                in_port = WIDTH'($urandom);
                hold    = $urandom_range(1, 9);
            end else begin
                hold--;
            end
            op         = $urandom_range(0, 9);
            address    = 2'($urandom);
            writedata  = $urandom;
            chipselect = (op < 4);
            write_n    = !((op < 3) || (op == 9));
            #1;
            total++;
            if (readdata !== exp_read(address)) begin
                bad++;
                $display("FAIL rand_read cyc=%0d addr=%0d got=%h want=%h", i, address, readdata,
                         exp_read(address));
            end
            total++;
            if (irq !== |(m_cap & m_mask)) begin
                bad++;
                $display("FAIL rand_irq cyc=%0d got=%b want=%b", i, irq, |(m_cap & m_mask));
            end
            tick();
        end
        chipselect = 1'b0; write_n = 1'b1;
    endtask

    initial begin
        test_reset();
        test_rise_latency();
        test_glitch();
        test_irq_mask();
        test_w1c_collision();
        test_reset_mid_debounce();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
